// File: rtl/div_acc_pkg.sv
// Shared definitions for the memory-mapped divider: register offsets,
// controller state encoding and STATUS/CTRL bit positions.
package div_acc_pkg;

    localparam logic [2:0] OFF_DIVIDEND = 3'd0;
    localparam logic [2:0] OFF_DIVISOR  = 3'd1;
    localparam logic [2:0] OFF_CTRL     = 3'd2;
    localparam logic [2:0] OFF_STATUS   = 3'd3;
    localparam logic [2:0] OFF_QUOT     = 3'd4;
    localparam logic [2:0] OFF_REM      = 3'd5;

    localparam int STATUS_DONE_BIT = 0;
    localparam int STATUS_ERR_BIT  = 1;
    localparam int STATUS_BUSY_BIT = 2;

    localparam int CTRL_GO_BIT = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_accelerator_if.sv
// Data-memory bus slice seen by the divider: address-decoded write strobe,
// word offset, write/read data and the Busy indication.
interface div_accelerator_if #(
    parameter int WIDTH = 32
);
    logic             WE;
    logic [2:0]       A;
    logic [WIDTH-1:0] WD;
    logic [WIDTH-1:0] RD;
    logic             Busy;

    modport master (
        output WE,
        output A,
        output WD,
        input  RD,
        input  Busy
    );

    modport slave (
        input  WE,
        input  A,
        input  WD,
        output RD,
        output Busy
    );
endinterface

// File: rtl/div_core.sv
// Restoring-division datapath: working remainder/quotient shift register,
// private divisor copy and step counter. The controller loads it at Go and
// steps it once per BUSY cycle; the next-step values are exposed so the
// final step can be committed on the same edge it is computed.
module div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quo_next_o,
    output logic [WIDTH-1:0] rem_next_o,
    output logic             last_step_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor at WIDTH+1 bits so the shifted-out MSB is kept.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, div_q};
        rem_d   = shifted[WIDTH-1:0];
        quo_d   = {quo_q[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    // Working registers: reloaded at Go, advanced once per step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            count_q <= '0;
        end else if (load_i) begin
            rem_q   <= '0;
            quo_q   <= dividend_i;
            div_q   <= divisor_i;
            count_q <= '0;
        end else if (step_i) begin
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            count_q <= count_q + CW'(1);
        end
    end

    assign quo_next_o  = quo_d;
    assign rem_next_o  = rem_d;
    assign last_step_o = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/div_accelerator.sv
// Memory-mapped iterative unsigned divider: operand/result register file,
// write decode, combinational read mux and the IDLE/BUSY/DONE controller.
module div_accelerator
    import div_acc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    div_accelerator_if.slave  bus
);

    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic             done_q;
    logic             err_q;
    logic             busy_q;
    div_state_e       state_q;

    logic             goWrite;
    logic             coreLoad;
    logic             coreStep;
    logic [WIDTH-1:0] coreQuoNext;
    logic [WIDTH-1:0] coreRemNext;
    logic             coreLastStep;
    logic [WIDTH-1:0] readData;

    assign goWrite  = bus.WE && (bus.A == OFF_CTRL) && bus.WD[CTRL_GO_BIT];
    assign coreLoad = goWrite && (state_q != BUSY) && (divisor_q != '0);
    assign coreStep = (state_q == BUSY);

    div_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .load_i     (coreLoad),
        .step_i     (coreStep),
        .dividend_i (dividend_q),
        .divisor_i  (divisor_q),
        .quo_next_o (coreQuoNext),
        .rem_next_o (coreRemNext),
        .last_step_o(coreLastStep)
    );

    // Operand write decode; accepted in every state since the core works on its own copy.
    always_comb begin
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        if (bus.WE && (bus.A == OFF_DIVIDEND)) begin
            dividend_d = bus.WD;
        end
        if (bus.WE && (bus.A == OFF_DIVISOR)) begin
            divisor_d = bus.WD;
        end
    end

    // Operand registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dividend_q <= '0;
            divisor_q  <= '0;
        end else begin
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
        end
    end

    // Controller: Go handling, divide-by-zero shortcut and result commit on the last step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            quot_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (goWrite) begin
                        if (divisor_q != '0) begin
                            state_q <= BUSY;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                            err_q   <= 1'b0;
                        end else begin
                            state_q <= DONE;
                            quot_q  <= '1;
                            rem_q   <= dividend_q;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (coreLastStep) begin
                        state_q <= DONE;
                        quot_q  <= coreQuoNext;
                        rem_q   <= coreRemNext;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Combinational read mux so a load sees the current register contents.
    always_comb begin
        readData = '0;
        case (bus.A)
            OFF_DIVIDEND: readData = dividend_q;
            OFF_DIVISOR:  readData = divisor_q;
            OFF_STATUS: begin
                readData[STATUS_DONE_BIT] = done_q;
                readData[STATUS_ERR_BIT]  = err_q;
                readData[STATUS_BUSY_BIT] = busy_q;
            end
            OFF_QUOT:     readData = quot_q;
            OFF_REM:      readData = rem_q;
            default:      readData = '0;
        endcase
    end

    assign bus.RD   = readData;
    assign bus.Busy = busy_q;

endmodule

// File: doc/div_accelerator.md
# div_accelerator

Memory-mapped iterative unsigned divider. It sits on the SoC data-memory bus next to the GPIO and factorial accelerator, as a responder to the pipelined MIPS core. The core writes the operands and a Go command, then polls status until the 32-cycle restoring division finishes. It then reads the quotient and remainder.

## Interface
Parameters:
- WIDTH, 32: operand, quotient and remainder width. The counter width is clog2(WIDTH)+1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low.
- WE  input  1  write enable for this peripheral, already address-decoded by the SoC.
- A  input  3  word offset within the block (bus address bits [4:2]).
- WD  input  WIDTH  write data.
- RD  output  WIDTH  read data; combinational from A.
- Busy  output  1  high while a division is in progress.

## Operation
Register map, by offset A:
- 0: DIVIDEND, read/write.
- 1: DIVISOR, read/write.
- 2: CTRL, write-only.
  - Writing with WD[0]=1 is Go.
  - Reads return 0.
- 3: STATUS, read-only: {0…, Busy, Err, Done} at bits [2:0].
- 4: QUOT, read-only.
- 5: REM, read-only.
- 6 and 7: read 0; writes are ignored.

Writes:
- A write to a read-only offset is ignored.
- A write to DIVIDEND or DIVISOR is accepted in any state.
- Such a write never disturbs an in-flight operation, because the operands are copied into working registers at Go.

FSM states are IDLE, BUSY and DONE.
- IDLE or DONE, Go with DIVISOR≠0:
  - Latch the working operands.
  - Clear Done and Err.
  - Set count=0 and go to BUSY.
- IDLE or DONE, Go with DIVISOR=0:
  - QUOT=all ones, REM=DIVIDEND.
  - Err=1, Done=1.
  - Go to DONE.
- BUSY, each edge, one restoring step:
  - Shift {rem, quo} left by one, bringing in the next dividend MSB.
  - If the shifted remainder is ≥ divisor, subtract the divisor and set the quotient LSB to 1.
  - Increment count.
- BUSY, when count=WIDTH−1: on that edge, commit QUOT and REM, set Done=1 and go to DONE.
- BUSY, Go: ignored, no restart and no error.

Other rules:
- Done and Err stay set until the next accepted Go or reset.
- QUOT and REM keep their last committed values until the next commit.
- Arithmetic is unsigned. The remainder compare uses a WIDTH+1-bit subtract, so the top bit shifted out is not lost.

## Timing
Reset values (rst low):
- State IDLE.
- DIVIDEND, DIVISOR, QUOT, REM and the working registers all 0.
- Done=0, Err=0, Busy=0, RD as decoded from A.

Latency, with Go written on edge k:
- Busy is high after edge k.
- Done=1 and Busy=0 after edge k+WIDTH, so 32 BUSY edges for WIDTH=32.
- Divide-by-zero: Done=1 and Err=1 after edge k; Busy never asserts.

Read behaviour:
- RD is combinational, so a load in the core's memory stage sees the current register contents.
- A STATUS read in the same cycle as the committing edge returns the pre-edge value.
- A write and a read on the same offset in one cycle: RD shows the old value; the new value appears after the edge.

Reset behaviour:
- rst asserted mid-BUSY aborts immediately (asynchronous).
- All registers return to their reset values; no partial result is committed.

## Structure
Shared package `div_acc_pkg` holds:
- Offset constants OFF_DIVIDEND=0, OFF_DIVISOR=1, OFF_CTRL=2, OFF_STATUS=3, OFF_QUOT=4, OFF_REM=5.
- The state encoding IDLE/BUSY/DONE.
- The STATUS bit positions.

Top `div_accelerator` contains the register file, write decode, read mux and FSM.

Sub-module `div_core` holds the datapath:
- Working remainder/quotient shift register, divisor copy and step counter.
- Inputs: load, step.
- Output: last_step.

## Test plan
- DIVIDEND=100, DIVISOR=7, Go:
  - Busy for 32 cycles.
  - Then STATUS=0b001, QUOT=14, REM=2.
- DIVIDEND=0xFFFFFFFF, DIVISOR=1, Go → QUOT=0xFFFFFFFF, REM=0. Then DIVISOR=0xFFFFFFFF, Go → QUOT=1, REM=0.
- DIVIDEND=5, DIVISOR=9 → QUOT=0, REM=5. Then DIVIDEND=0, DIVISOR=3 → QUOT=0, REM=0.
- DIVISOR=0, DIVIDEND=42, Go:
  - After one edge: STATUS=0b011, QUOT=0xFFFFFFFF, REM=42, Busy never high.
  - A following valid Go clears Err.
- Start 100/7; at cycle 10 write DIVIDEND=1000 and issue Go again:
  - The result is still 14 r 2, completing at the original cycle.
  - Reading DIVIDEND returns 1000.
- Start 100/7; pull rst low at cycle 15:
  - All readable registers are 0 and STATUS=0.
  - A fresh Go afterwards produces the correct result.
